// File: rtl/tinyalu_pkg.sv
// Shared TinyALU types: opcode encodings, command-master FSM states and data widths.
package tinyalu_pkg;

  localparam int ALU_DATA_W = 8;
  localparam int ALU_RES_W  = 16;

  typedef enum logic [2:0] {
    no_op  = 3'b000,
    add_op = 3'b001,
    and_op = 3'b010,
    xor_op = 3'b011,
    mul_op = 3'b100,
    rst_op = 3'b111
  } operation_t;

  typedef enum logic [2:0] {
    IDLE,
    ALU_WAIT,
    NOP_PULSE,
    RST_PULSE,
    RESP
  } cmd_master_state_t;

  // Opcodes that make the ALU produce a result (and therefore a response).
  function automatic logic is_alu_op(input operation_t op);
    return (op == add_op) || (op == and_op) || (op == xor_op) || (op == mul_op);
  endfunction

endpackage

// File: rtl/tinyalu_cmd_master_wdog.sv
// ALU_WAIT watchdog: counts cycles while i_run is high, flags expiry on the last allowed cycle.
module tinyalu_cmd_master_wdog #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_run,
  output logic o_expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] r_cnt;

  // Counter sits at zero outside the wait state, so it is clear on every entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (!i_run) begin
      r_cnt <= '0;
    end else if (!o_expired) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expired = i_run && (r_cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/tinyalu_cmd_master.sv
// TinyALU start/done initiator: command stream in, ALU pins out, result stream back.
// Optional ALU_WAIT timeout enabled by defining TINYALU_CMD_MASTER_TIMEOUT_EN.
module tinyalu_cmd_master
  import tinyalu_pkg::*;
#(
  parameter int RST_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ALU_DATA_W-1:0] cmd_a,
  input  logic [ALU_DATA_W-1:0] cmd_b,
  input  logic [2:0]            cmd_op,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ALU_RES_W-1:0]  rsp_result,
  output logic [2:0]            rsp_op,
  output logic                  rsp_err,
  output logic [ALU_DATA_W-1:0] alu_a,
  output logic [ALU_DATA_W-1:0] alu_b,
  output logic [2:0]            alu_op,
  output logic                  alu_start,
  input  logic                  alu_done,
  input  logic [ALU_RES_W-1:0]  alu_result,
  output logic                  alu_reset_n
);

  localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  cmd_master_state_t     r_state, w_state_next;
  logic                  r_cmd_ready, w_cmd_ready_next;
  logic                  r_rsp_valid, w_rsp_valid_next;
  logic [ALU_RES_W-1:0]  r_rsp_result, w_rsp_result_next;
  logic [2:0]            r_rsp_op, w_rsp_op_next;
  logic [ALU_DATA_W-1:0] r_alu_a, w_alu_a_next;
  logic [ALU_DATA_W-1:0] r_alu_b, w_alu_b_next;
  logic [2:0]            r_alu_op, w_alu_op_next;
  logic                  r_alu_start, w_alu_start_next;
  logic                  r_alu_reset_n, w_alu_reset_n_next;
  logic [RC_W-1:0]       r_rst_cnt, w_rst_cnt_next;
  operation_t            w_cmd_op;

`ifdef TINYALU_CMD_MASTER_TIMEOUT_EN
  logic r_rsp_err, w_rsp_err_next;
  logic w_wdog_expired;

  tinyalu_cmd_master_wdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_run    (r_state == ALU_WAIT),
    .o_expired(w_wdog_expired)
  );

  assign rsp_err = r_rsp_err;
`else
  assign rsp_err = 1'b0;
`endif

  assign w_cmd_op = operation_t'(cmd_op);

  always_comb begin
    w_state_next       = r_state;
    w_rsp_valid_next   = r_rsp_valid;
    w_rsp_result_next  = r_rsp_result;
    w_rsp_op_next      = r_rsp_op;
    w_alu_a_next       = r_alu_a;
    w_alu_b_next       = r_alu_b;
    w_alu_op_next      = r_alu_op;
    w_alu_start_next   = r_alu_start;
    w_alu_reset_n_next = 1'b1;
    w_rst_cnt_next     = r_rst_cnt;
`ifdef TINYALU_CMD_MASTER_TIMEOUT_EN
    w_rsp_err_next     = r_rsp_err;
`endif
    case (r_state)
      IDLE: begin
        if (cmd_valid && r_cmd_ready) begin
          if (is_alu_op(w_cmd_op)) begin
            w_alu_a_next     = cmd_a;
            w_alu_b_next     = cmd_b;
            w_alu_op_next    = cmd_op;
            w_alu_start_next = 1'b1;
            w_state_next     = ALU_WAIT;
          end else if (w_cmd_op == rst_op) begin
            w_alu_reset_n_next = 1'b0;
            w_rst_cnt_next     = RC_W'(RST_CYCLES - 1);
            w_state_next       = RST_PULSE;
          end else begin
            // no_op and the unused codes all become a bare no_op strobe
            w_alu_op_next    = no_op;
            w_alu_start_next = 1'b1;
            w_state_next     = NOP_PULSE;
          end
        end
      end
      ALU_WAIT: begin
        if (alu_done) begin
          w_rsp_result_next = alu_result;
          w_rsp_op_next     = r_alu_op;
          w_alu_start_next  = 1'b0;
          w_rsp_valid_next  = 1'b1;
          w_state_next      = RESP;
`ifdef TINYALU_CMD_MASTER_TIMEOUT_EN
          w_rsp_err_next    = 1'b0;
        end else if (w_wdog_expired) begin
          w_rsp_result_next = '0;
          w_rsp_op_next     = r_alu_op;
          w_alu_start_next  = 1'b0;
          w_rsp_valid_next  = 1'b1;
          w_rsp_err_next    = 1'b1;
          w_state_next      = RESP;
`endif
        end
      end
      NOP_PULSE: begin
        w_alu_start_next = 1'b0;
        w_state_next     = IDLE;
      end
      RST_PULSE: begin
        if (r_rst_cnt == '0) begin
          w_state_next = IDLE;
        end else begin
          w_alu_reset_n_next = 1'b0;
          w_rst_cnt_next     = r_rst_cnt - 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          w_rsp_valid_next = 1'b0;
          w_state_next     = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
    w_cmd_ready_next = (w_state_next == IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_cmd_ready   <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_result  <= '0;
      r_rsp_op      <= 3'b000;
      r_alu_a       <= '0;
      r_alu_b       <= '0;
      r_alu_op      <= 3'b000;
      r_alu_start   <= 1'b0;
      r_alu_reset_n <= 1'b0;
      r_rst_cnt     <= '0;
`ifdef TINYALU_CMD_MASTER_TIMEOUT_EN
      r_rsp_err     <= 1'b0;
`endif
    end else begin
      r_state       <= w_state_next;
      r_cmd_ready   <= w_cmd_ready_next;
      r_rsp_valid   <= w_rsp_valid_next;
      r_rsp_result  <= w_rsp_result_next;
      r_rsp_op      <= w_rsp_op_next;
      r_alu_a       <= w_alu_a_next;
      r_alu_b       <= w_alu_b_next;
      r_alu_op      <= w_alu_op_next;
      r_alu_start   <= w_alu_start_next;
      r_alu_reset_n <= w_alu_reset_n_next;
      r_rst_cnt     <= w_rst_cnt_next;
`ifdef TINYALU_CMD_MASTER_TIMEOUT_EN
      r_rsp_err     <= w_rsp_err_next;
`endif
    end
  end

  assign cmd_ready   = r_cmd_ready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_result  = r_rsp_result;
  assign rsp_op      = r_rsp_op;
  assign alu_a       = r_alu_a;
  assign alu_b       = r_alu_b;
  assign alu_op      = r_alu_op;
  assign alu_start   = r_alu_start;
  assign alu_reset_n = r_alu_reset_n;

endmodule

// File: tb/tb_tinyalu_cmd_master.sv
// Scoreboard bench for tinyalu_cmd_master paired with a behavioural TinyALU
// (single-cycle ops done after one cycle, mul done after three).
module tb_tinyalu_cmd_master;
  import tinyalu_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid, cmd_ready;
  logic [7:0]  cmd_a, cmd_b;
  logic [2:0]  cmd_op;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_result;
  logic [2:0]  rsp_op;
  logic        rsp_err;
  logic [7:0]  alu_a, alu_b;
  logic [2:0]  alu_op;
  logic        alu_start, alu_done, alu_reset_n;
  logic [15:0] alu_result;

  always #5 clk = ~clk;

  tinyalu_cmd_master dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_op(rsp_op),
    .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_start(alu_start),
    .alu_done(alu_done), .alu_result(alu_result), .alu_reset_n(alu_reset_n)
  );

  // Behavioural TinyALU
  logic        m_done;
  logic [1:0]  m_cnt;
  logic [15:0] m_res;
  logic        force_done_low = 1'b0;

  always @(posedge clk) begin
    if (!alu_reset_n) begin
      m_done <= 1'b0;
      m_cnt  <= 2'd0;
      m_res  <= 16'h0;
    end else begin
      m_done <= 1'b0;
      if (alu_start && !m_done) begin
        if (alu_op == 3'b100) begin
          if (m_cnt == 2'd2) begin
            m_done <= 1'b1;
            m_res  <= alu_a * alu_b;
            m_cnt  <= 2'd0;
          end else begin
            m_cnt <= m_cnt + 2'd1;
          end
        end else if (alu_op != 3'b000) begin
          m_done <= 1'b1;
          case (alu_op)
            3'b001:  m_res <= {8'h00, alu_a} + {8'h00, alu_b};
            3'b010:  m_res <= {8'h00, alu_a & alu_b};
            default: m_res <= {8'h00, alu_a ^ alu_b};
          endcase
        end
      end else begin
        m_cnt <= 2'd0;
      end
    end
  end

  assign alu_done   = m_done & ~force_done_low;
  assign alu_result = m_res;

  // Scoreboard: {result[15:0], op[2:0], err}
  logic [19:0] exp_q[$];
  logic [19:0] mon_e;
  int n_checks = 0;
  int n_pass   = 0;
  int n_rsp    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: handshake completes at the posedge following this negedge
  always @(negedge clk) begin
    if (reset_n && rsp_valid && rsp_ready) begin
      n_rsp++;
      $display("rsp: result=0x%04h op=%03b err=%0b", rsp_result, rsp_op, rsp_err);
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_rsp: got result 0x%04h op %03b, required no response", rsp_result, rsp_op);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_result", 32'(rsp_result), 32'(mon_e[19:4]));
        check("rsp_op", 32'(rsp_op), 32'(mon_e[3:1]));
        check("rsp_err", 32'(rsp_err), 32'(mon_e[0]));
        check("start_low_at_rsp", 32'(alu_start), 32'd0);
      end
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    int t = 0;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = op;
    $display("cmd: a=0x%02h b=0x%02h op=%03b", a, b, op);
    @(negedge clk);
    while (!cmd_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ctl"}, {26'd0, cmd_ready, rsp_valid, rsp_err, alu_start, alu_reset_n, 1'b0}, 32'd0);
    check({tag, "_rsp"}, {13'd0, rsp_result, rsp_op}, 32'd0);
    check({tag, "_alu"}, {13'd0, alu_a, alu_b, alu_op}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running, required completion");
    $fatal(1, "global timeout");
  end

  initial begin
    int n;
    int r0;
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0; rsp_ready = 1'b0;
    #3;
    check_reset_vals("reset");
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("alu_reset_n_release", 32'(alu_reset_n), 32'd1);
    check("cmd_ready_idle", 32'(cmd_ready), 32'd1);

    // 1: add
    rsp_ready = 1'b1;
    exp_q.push_back({16'h0046, 3'b001, 1'b0});
    send(8'h12, 8'h34, 3'b001);
    check("add_drive", {9'd0, alu_start, alu_a, alu_b, alu_op, 3'd0}, {9'd0, 1'b1, 8'h12, 8'h34, 3'b001, 3'd0});
    drain();

    // 2: mul 0xFF*0xFF, start held at least three cycles, no accept meanwhile
    exp_q.push_back({16'hFE01, 3'b100, 1'b0});
    send(8'hFF, 8'hFF, 3'b100);
    n = 0; r0 = 0;
    @(negedge clk);
    while (alu_start && n < 20) begin
      n++;
      if (cmd_ready) r0++;
      @(negedge clk);
    end
    check("mul_start_ge3", 32'(n >= 3), 32'd1);
    check("mul_cmd_ready_low", 32'(r0), 32'd0);
    drain();

    // 3: xor with response stalled, second command offered
    rsp_ready = 1'b0;
    exp_q.push_back({16'h00CC, 3'b011, 1'b0});
    send(8'hF0, 8'h3C, 3'b011);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    cmd_valid = 1'b1; cmd_a = 8'h01; cmd_b = 8'h02; cmd_op = 3'b001;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
      check("stall_rsp_result", 32'(rsp_result), 32'h00CC);
      check("stall_cmd_ready", 32'(cmd_ready), 32'd0);
      check("stall_no_start", 32'(alu_start), 32'd0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    drain();
    @(negedge clk); @(negedge clk);
    check("second_cmd_dropped", 32'(alu_start), 32'd0);

    // 4: rst_op then no_op and an unused code; no responses
    r0 = n_rsp;
    send(8'h00, 8'h00, 3'b111);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (!alu_reset_n) n++;
      if (alu_start) n += 100;
    end
    check("rst_pulse_cycles", 32'(n), 32'd2);
    send(8'h00, 8'h00, 3'b000);
    n = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (alu_start) n += (alu_op == 3'b000) ? 1 : 100;
    end
    check("nop_start_cycles", 32'(n), 32'd1);
    send(8'h55, 8'hAA, 3'b101);
    n = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (alu_start) n += (alu_op == 3'b000) ? 1 : 100;
    end
    check("unused_op_start_cycles", 32'(n), 32'd1);
    repeat (4) @(negedge clk);
    check("no_rsp_rst_nop", 32'(n_rsp), 32'(r0));

    // 5: reset mid-mul
    r0 = n_rsp;
    send(8'h07, 8'h09, 3'b100);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check_reset_vals("midreset");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    check("no_rsp_after_reset", 32'(n_rsp), 32'(r0));
    exp_q.push_back({16'h0002, 3'b001, 1'b0});
    send(8'h01, 8'h01, 3'b001);
    drain();
    check("one_rsp_after_reset", 32'(n_rsp), 32'(r0 + 1));

`ifdef TINYALU_CMD_MASTER_TIMEOUT_EN
    // 6: timeout
    force_done_low = 1'b1;
    exp_q.push_back({16'h0000, 3'b001, 1'b1});
    send(8'h05, 8'h05, 3'b001);
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("timeout_cycles", 32'(n), 32'd16);
    drain();
    @(negedge clk);
    force_done_low = 1'b0;
`endif

    repeat (3) @(negedge clk);
    check("queue_empty_end", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
